// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: states, opcodes,
// funct codes, select encodings and the decoded instruction class.
package mc_pkg;

   localparam logic [2:0] FETCH = 3'd0;
   localparam logic [2:0] DCD   = 3'd1;
   localparam logic [2:0] EXE   = 3'd2;
   localparam logic [2:0] MEM   = 3'd3;
   localparam logic [2:0] WB    = 3'd4;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUBU = 6'h23;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_OR  = 2'b10;
   localparam logic [1:0] ALU_LUI = 2'b11;

   localparam logic [1:0] NPC_PC4  = 2'b00;
   localparam logic [1:0] NPC_BR   = 2'b01;
   localparam logic [1:0] NPC_JUMP = 2'b10;
   localparam logic [1:0] NPC_JR   = 2'b11;

   localparam logic [1:0] RD_RT = 2'b00;
   localparam logic [1:0] RD_RD = 2'b01;
   localparam logic [1:0] RD_RA = 2'b10;

   localparam logic [1:0] WD_ALU = 2'b00;
   localparam logic [1:0] WD_DM  = 2'b01;
   localparam logic [1:0] WD_PC4 = 2'b10;

   localparam logic [1:0] EXT_ZERO = 2'b00;
   localparam logic [1:0] EXT_SIGN = 2'b01;
   localparam logic [1:0] EXT_HIGH = 2'b10;

   typedef struct packed {
      logic rtype;
      logic subu;
      logic jr;
      logic ori;
      logic lw;
      logic sw;
      logic beq;
      logic lui;
      logic j;
      logic jal;
      logic illegal;
   } instrClass_t;

   typedef struct packed {
      logic       pcWr;
      logic       irWr;
      logic       gprWr;
      logic       dmWr;
      logic       aluSrc;
      logic [1:0] npcOp;
      logic [1:0] regDst;
      logic [1:0] wdSel;
      logic [1:0] aluOp;
      logic [1:0] extOp;
   } ctrl_t;

   function automatic logic isMemOp(instrClass_t c);
      return c.lw | c.sw;
   endfunction

endpackage

// File: rtl/mc_decode.sv
// Pure combinational opcode/funct classifier.
// jal is recognised only when MC_CTRL_JAL_EN is defined.
module mc_decode
   import mc_pkg::*;
(
   input  logic [5:0]  op,
   input  logic [5:0]  funct,
   output instrClass_t cls
);

   always_comb begin
      cls = '0;
      unique case (1'b1)
         op == OP_RTYPE: begin
            unique case (1'b1)
               funct == FN_ADDU: cls.rtype = 1'b1;
               funct == FN_SUBU: begin
                  cls.rtype = 1'b1;
                  cls.subu  = 1'b1;
               end
               funct == FN_JR: cls.jr = 1'b1;
               default: cls.illegal = 1'b1;
            endcase
         end
         op == OP_ORI: cls.ori = 1'b1;
         op == OP_LW:  cls.lw  = 1'b1;
         op == OP_SW:  cls.sw  = 1'b1;
         op == OP_BEQ: cls.beq = 1'b1;
         op == OP_LUI: cls.lui = 1'b1;
         op == OP_J:   cls.j   = 1'b1;
`ifdef MC_CTRL_JAL_EN
         op == OP_JAL: cls.jal = 1'b1;
`endif
         default: cls.illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM with retired counter and sticky illegal flag.
// Define MC_CTRL_JAL_EN to execute jal in DCD instead of flagging it.
module mc_ctrl
   import mc_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  op,
   input  logic [5:0]  funct,
   input  logic        zero,
   output logic        PCWr,
   output logic        IRWr,
   output logic        GPRWr,
   output logic        DMWr,
   output logic        ALUSrc,
   output logic [1:0]  NPCOp,
   output logic [1:0]  RegDst,
   output logic [1:0]  WDSel,
   output logic [1:0]  ALUOp,
   output logic [1:0]  EXTOp,
   output logic [2:0]  state_o,
   output logic        illegal,
   output logic [31:0] retired
);

   logic [2:0]  state;
   logic [2:0]  nextState;
   logic [5:0]  opQ;
   logic [5:0]  functQ;
   logic [5:0]  curOp;
   logic [5:0]  curFunct;
   logic        retire;
   instrClass_t cls;
   ctrl_t       ctl;
   ctrl_t       ctlOut;

   // DCD decides on the live IR fields it is latching; later states use the copy
   assign curOp    = (state == DCD) ? op : opQ;
   assign curFunct = (state == DCD) ? funct : functQ;

   mc_decode uDecode (
      .op    (curOp),
      .funct (curFunct),
      .cls   (cls)
   );

   always_comb begin
      ctl       = '0;
      nextState = FETCH;
      unique case (1'b1)
         state == FETCH: begin
            ctl.pcWr  = 1'b1;
            ctl.irWr  = 1'b1;
            ctl.npcOp = NPC_PC4;
            nextState = DCD;
         end
         state == DCD: begin
            unique case (1'b1)
               cls.j: begin
                  ctl.pcWr  = 1'b1;
                  ctl.npcOp = NPC_JUMP;
               end
               cls.jr: begin
                  ctl.pcWr  = 1'b1;
                  ctl.npcOp = NPC_JR;
               end
               cls.jal: begin
                  ctl.pcWr   = 1'b1;
                  ctl.npcOp  = NPC_JUMP;
                  ctl.gprWr  = 1'b1;
                  ctl.regDst = RD_RA;
                  ctl.wdSel  = WD_PC4;
               end
               cls.illegal: nextState = FETCH;
               default: nextState = EXE;
            endcase
         end
         state == EXE: begin
            unique case (1'b1)
               cls.beq: begin
                  ctl.aluOp = ALU_SUB;
                  ctl.pcWr  = zero;
                  ctl.npcOp = NPC_BR;
               end
               isMemOp(cls): begin
                  ctl.aluSrc = 1'b1;
                  ctl.extOp  = EXT_SIGN;
                  ctl.aluOp  = ALU_ADD;
                  nextState  = MEM;
               end
               cls.ori: begin
                  ctl.aluSrc = 1'b1;
                  ctl.extOp  = EXT_ZERO;
                  ctl.aluOp  = ALU_OR;
                  nextState  = WB;
               end
               cls.lui: begin
                  ctl.aluSrc = 1'b1;
                  ctl.extOp  = EXT_HIGH;
                  ctl.aluOp  = ALU_LUI;
                  nextState  = WB;
               end
               cls.rtype: begin
                  ctl.aluOp = cls.subu ? ALU_SUB : ALU_ADD;
                  nextState = WB;
               end
               default: nextState = FETCH;
            endcase
         end
         state == MEM: begin
            ctl.dmWr  = cls.sw;
            nextState = cls.lw ? WB : FETCH;
         end
         state == WB: begin
            ctl.gprWr  = 1'b1;
            ctl.regDst = cls.rtype ? RD_RD : RD_RT;
            ctl.wdSel  = cls.lw ? WD_DM : WD_ALU;
         end
         default: nextState = FETCH;
      endcase
   end

   // Gating with rst kills any in-flight GPR/DM write the moment reset drops
   assign ctlOut = rst ? ctl : '0;

   assign PCWr    = ctlOut.pcWr;
   assign IRWr    = ctlOut.irWr;
   assign GPRWr   = ctlOut.gprWr;
   assign DMWr    = ctlOut.dmWr;
   assign ALUSrc  = ctlOut.aluSrc;
   assign NPCOp   = ctlOut.npcOp;
   assign RegDst  = ctlOut.regDst;
   assign WDSel   = ctlOut.wdSel;
   assign ALUOp   = ctlOut.aluOp;
   assign EXTOp   = ctlOut.extOp;
   assign state_o = state;

   assign retire = (nextState == FETCH)
                 && (state >= DCD) && (state <= WB)
                 && !((state == DCD) && cls.illegal);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= FETCH;
         opQ     <= '0;
         functQ  <= '0;
         illegal <= 1'b0;
         retired <= '0;
      end else begin
         state <= nextState;
         if (state == DCD) begin
            opQ    <= op;
            functQ <= funct;
         end
         if ((state == DCD) && cls.illegal)
            illegal <= 1'b1;
         if (retire)
            retired <= retired + 32'd1;
      end
   end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: per-state control words and counters.
// Define MC_CTRL_JAL_EN for both bench and RTL to test the jal build.
module tb_mc_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [5:0]  op = '0;
   logic [5:0]  funct = '0;
   logic        zero = 1'b0;
   logic        PCWr, IRWr, GPRWr, DMWr, ALUSrc;
   logic [1:0]  NPCOp, RegDst, WDSel, ALUOp, EXTOp;
   logic [2:0]  state_o;
   logic        illegal;
   logic [31:0] retired;
   logic [14:0] ctlObs;

   int checks = 0;
   int failures = 0;

   mc_ctrl dut (
      .clk     (clk),
      .rst     (rst),
      .op      (op),
      .funct   (funct),
      .zero    (zero),
      .PCWr    (PCWr),
      .IRWr    (IRWr),
      .GPRWr   (GPRWr),
      .DMWr    (DMWr),
      .ALUSrc  (ALUSrc),
      .NPCOp   (NPCOp),
      .RegDst  (RegDst),
      .WDSel   (WDSel),
      .ALUOp   (ALUOp),
      .EXTOp   (EXTOp),
      .state_o (state_o),
      .illegal (illegal),
      .retired (retired)
   );

   always #5 clk = ~clk;

   assign ctlObs = {PCWr, IRWr, GPRWr, DMWr, ALUSrc,
                    NPCOp, RegDst, WDSel, ALUOp, EXTOp};

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [14:0] c(input int pc, input int ir,
         input int gpr, input int dm, input int src, input int npc,
         input int rd, input int wd, input int alu, input int ext);
      return {pc[0], ir[0], gpr[0], dm[0], src[0],
              npc[1:0], rd[1:0], wd[1:0], alu[1:0], ext[1:0]};
   endfunction

   logic [14:0] fCtl;
   logic [14:0] nCtl;

   task automatic cyc(input string tag, input logic [2:0] st,
                      input logic [14:0] ex);
      #1;
      chk({tag, ".st"}, 32'(state_o), 32'(st));
      chk({tag, ".ctl"}, 32'(ctlObs), 32'(ex));
      @(negedge clk);
   endtask

   task automatic start(input string tag, input logic [5:0] o,
         input logic [5:0] f, input logic z,
         input logic [31:0] ret, input logic ill);
      op = o;
      funct = f;
      zero = z;
      #1;
      chk({tag, ".ret"}, retired, ret);
      chk({tag, ".ill"}, 32'(illegal), 32'(ill));
      cyc({tag, ".F"}, 3'd0, fCtl);
   endtask

   initial begin
      fCtl = c(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      nCtl = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst.st", 32'(state_o), 32'd0);
      chk("rst.ctl", 32'(ctlObs), 32'd0);
      chk("rst.ret", retired, 32'd0);
      chk("rst.ill", 32'(illegal), 32'd0);
      @(negedge clk);
      rst = 1'b1;

      start("addu", 6'h00, 6'h21, 1'b0, 32'd0, 1'b0);
      cyc("addu.D", 3'd1, nCtl);
      op = 6'h3F;
      funct = 6'h3F;
      cyc("addu.E", 3'd2, nCtl);
      cyc("addu.W", 3'd4, c(0, 0, 1, 0, 0, 0, 1, 0, 0, 0));

      start("beq1", 6'h04, 6'h00, 1'b1, 32'd1, 1'b0);
      cyc("beq1.D", 3'd1, nCtl);
      cyc("beq1.E", 3'd2, c(1, 0, 0, 0, 0, 1, 0, 0, 1, 0));

      start("beq0", 6'h04, 6'h00, 1'b0, 32'd2, 1'b0);
      cyc("beq0.D", 3'd1, nCtl);
      cyc("beq0.E", 3'd2, c(0, 0, 0, 0, 0, 1, 0, 0, 1, 0));

      start("lw", 6'h23, 6'h00, 1'b0, 32'd3, 1'b0);
      cyc("lw.D", 3'd1, nCtl);
      cyc("lw.E", 3'd2, c(0, 0, 0, 0, 1, 0, 0, 0, 0, 1));
      cyc("lw.M", 3'd3, nCtl);
      cyc("lw.W", 3'd4, c(0, 0, 1, 0, 0, 0, 0, 1, 0, 0));

      start("sw", 6'h2B, 6'h00, 1'b0, 32'd4, 1'b0);
      cyc("sw.D", 3'd1, nCtl);
      cyc("sw.E", 3'd2, c(0, 0, 0, 0, 1, 0, 0, 0, 0, 1));
      cyc("sw.M", 3'd3, c(0, 0, 0, 1, 0, 0, 0, 0, 0, 0));

      start("bad", 6'h3F, 6'h00, 1'b0, 32'd5, 1'b0);
      cyc("bad.D", 3'd1, nCtl);

      start("ori", 6'h0D, 6'h00, 1'b0, 32'd5, 1'b1);
      cyc("ori.D", 3'd1, nCtl);
      cyc("ori.E", 3'd2, c(0, 0, 0, 0, 1, 0, 0, 0, 2, 0));
      cyc("ori.W", 3'd4, c(0, 0, 1, 0, 0, 0, 0, 0, 0, 0));

      start("lui", 6'h0F, 6'h00, 1'b0, 32'd6, 1'b1);
      cyc("lui.D", 3'd1, nCtl);
      cyc("lui.E", 3'd2, c(0, 0, 0, 0, 1, 0, 0, 0, 3, 2));
      cyc("lui.W", 3'd4, c(0, 0, 1, 0, 0, 0, 0, 0, 0, 0));

      start("subu", 6'h00, 6'h23, 1'b0, 32'd7, 1'b1);
      cyc("subu.D", 3'd1, nCtl);
      cyc("subu.E", 3'd2, c(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
      cyc("subu.W", 3'd4, c(0, 0, 1, 0, 0, 0, 1, 0, 0, 0));

      start("j", 6'h02, 6'h00, 1'b0, 32'd8, 1'b1);
      cyc("j.D", 3'd1, c(1, 0, 0, 0, 0, 2, 0, 0, 0, 0));

      start("jr", 6'h00, 6'h08, 1'b0, 32'd9, 1'b1);
      cyc("jr.D", 3'd1, c(1, 0, 0, 0, 0, 3, 0, 0, 0, 0));

      start("lwab", 6'h23, 6'h00, 1'b0, 32'd10, 1'b1);
      cyc("lwab.D", 3'd1, nCtl);
      cyc("lwab.E", 3'd2, c(0, 0, 0, 0, 1, 0, 0, 0, 0, 1));
      cyc("lwab.M", 3'd3, nCtl);
      #1;
      chk("lwab.W.gpr", 32'(GPRWr), 32'd1);
      rst = 1'b0;
      #1;
      chk("abort.gpr", 32'(GPRWr), 32'd0);
      chk("abort.ctl", 32'(ctlObs), 32'd0);
      chk("abort.st", 32'(state_o), 32'd0);
      chk("abort.ret", retired, 32'd0);
      chk("abort.ill", 32'(illegal), 32'd0);
      @(negedge clk);
      rst = 1'b1;

      start("jal", 6'h03, 6'h00, 1'b0, 32'd0, 1'b0);
`ifdef MC_CTRL_JAL_EN
      cyc("jal.D", 3'd1, c(1, 0, 1, 0, 0, 2, 2, 2, 0, 0));
      #1;
      chk("jal.ret", retired, 32'd1);
      chk("jal.ill", 32'(illegal), 32'd0);
`else
      cyc("jal.D", 3'd1, nCtl);
      #1;
      chk("jal.ret", retired, 32'd0);
      chk("jal.ill", 32'(illegal), 32'd1);
`endif
      chk("jal.st", 32'(state_o), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
